// File: rtl/ram_port_arbiter.sv
// rtl/ram_port_arbiter.sv - two-requester round-robin sequencer for a single-port synchronous RAM
// Define ARB_FIXED_PRIO_EN to make requester 0 win every tie (requester 1 may starve).
module ram_port_arbiter #(
  parameter int DATA_WIDTH     = 8,
  parameter int ADDR_BUS_WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      req0,
  input  logic                      req1,
  input  logic                      we0,
  input  logic                      we1,
  input  logic [ADDR_BUS_WIDTH-1:0] addr0,
  input  logic [ADDR_BUS_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0]     wdata0,
  input  logic [DATA_WIDTH-1:0]     wdata1,
  output logic                      gnt0,
  output logic                      gnt1,
  output logic                      rvalid0,
  output logic                      rvalid1,
  output logic [DATA_WIDTH-1:0]     rdata,
  output logic                      read_en,
  output logic                      write_en,
  output logic [ADDR_BUS_WIDTH-1:0] address_loc,
  output logic [DATA_WIDTH-1:0]     data_in,
  input  logic [DATA_WIDTH-1:0]     data_out
);

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE} state_t;

  state_t                    state, state_n;
  logic                      last_grant, last_grant_n;
  logic                      winner, winner_n;
  logic                      pick, pick_we;
  logic                      gnt0_n, gnt1_n, rvalid0_n, rvalid1_n;
  logic                      read_en_n, write_en_n;
  logic [ADDR_BUS_WIDTH-1:0] address_n;
  logic [DATA_WIDTH-1:0]     data_in_n, rdata_n;

  // pick = 1 selects requester 1
  always_comb begin
`ifdef ARB_FIXED_PRIO_EN
    pick = ~req0;
`else
    pick = (req0 && req1) ? ~last_grant : ~req0;
`endif
    pick_we = pick ? we1 : we0;
  end

  always_comb begin
    state_n      = state;
    last_grant_n = last_grant;
    winner_n     = winner;
    gnt0_n       = 1'b0;
    gnt1_n       = 1'b0;
    rvalid0_n    = 1'b0;
    rvalid1_n    = 1'b0;
    read_en_n    = 1'b0;
    write_en_n   = 1'b0;
    address_n    = address_loc;
    data_in_n    = data_in;
    rdata_n      = rdata;
    case (state)
      IDLE: begin
        if (req0 || req1) begin
          winner_n     = pick;
          last_grant_n = pick;
          gnt0_n       = ~pick;
          gnt1_n       = pick;
          address_n    = pick ? addr1 : addr0;
          data_in_n    = pick ? wdata1 : wdata0;
          read_en_n    = ~pick_we;
          write_en_n   = pick_we;
          state_n      = ISSUE;
        end
      end
      // RAM samples the strobes at the edge leaving this state
      ISSUE: state_n = read_en ? CAPTURE : IDLE;
      CAPTURE: begin
        rdata_n   = data_out;
        rvalid0_n = ~winner;
        rvalid1_n = winner;
        state_n   = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      last_grant  <= 1'b1;
      winner      <= 1'b0;
      gnt0        <= 1'b0;
      gnt1        <= 1'b0;
      rvalid0     <= 1'b0;
      rvalid1     <= 1'b0;
      read_en     <= 1'b0;
      write_en    <= 1'b0;
      address_loc <= '0;
      data_in     <= '0;
      rdata       <= '0;
    end else begin
      state       <= state_n;
      last_grant  <= last_grant_n;
      winner      <= winner_n;
      gnt0        <= gnt0_n;
      gnt1        <= gnt1_n;
      rvalid0     <= rvalid0_n;
      rvalid1     <= rvalid1_n;
      read_en     <= read_en_n;
      write_en    <= write_en_n;
      address_loc <= address_n;
      data_in     <= data_in_n;
      rdata       <= rdata_n;
    end
  end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb/tb_ram_port_arbiter.sv - scoreboard bench for ram_port_arbiter with a behavioural RAM
module tb_ram_port_arbiter;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req0 = 0, req1 = 0, we0 = 0, we1 = 0;
  logic [7:0] addr0 = 0, addr1 = 0, wdata0 = 0, wdata1 = 0;
  logic       gnt0, gnt1, rvalid0, rvalid1, read_en, write_en;
  logic [7:0] rdata, address_loc, data_in;
  logic [7:0] data_out = 8'h00;

  logic [7:0] mem [256];
  logic [7:0] shadow [256];
  logic [7:0] exp0 [$];
  logic [7:0] exp1 [$];
  int         gnt_log [$];
  int         errors = 0, checks = 0;
  int         cyc = 0, rd_cnt = 0, wr_cnt = 0;

  ram_port_arbiter #(.DATA_WIDTH(8), .ADDR_BUS_WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1), .rdata(rdata),
    .read_en(read_en), .write_en(write_en), .address_loc(address_loc),
    .data_in(data_in), .data_out(data_out)
  );

  always #5 clk = ~clk;

  // RAM has no reset; read data appears the cycle after the strobe
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (write_en) mem[address_loc] <= data_in;
    if (read_en) data_out <= mem[address_loc];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      check("exclusive", {30'd0, read_en & write_en, 1'b0} | {31'd0, gnt0 & gnt1}
            | {29'd0, rvalid0 & rvalid1, 2'b0}, 32'd0);
      if (read_en) rd_cnt++;
      if (write_en) wr_cnt++;
      if (gnt0) gnt_log.push_back(0);
      if (gnt1) gnt_log.push_back(1);
      if (rvalid0) begin
        if (exp0.size() == 0) check("rvalid0_unexpected", 1, 0);
        else check("rdata0", {24'd0, rdata}, {24'd0, exp0.pop_front()});
      end
      if (rvalid1) begin
        if (exp1.size() == 0) check("rvalid1_unexpected", 1, 0);
        else check("rdata1", {24'd0, rdata}, {24'd0, exp1.pop_front()});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one command, wait for its grant, then record what the scoreboard should see
  task automatic do_cmd(input int id, input logic w, input logic [7:0] a, input logic [7:0] d);
    bit got = 0;
    if (id == 0) begin we0 = w; addr0 = a; wdata0 = d; req0 = 1; end
    else begin we1 = w; addr1 = a; wdata1 = d; req1 = 1; end
    for (int i = 0; i < 20 && !got; i++) begin
      tick();
      got = (id == 0) ? gnt0 : gnt1;
    end
    check("gnt_seen", {31'd0, got}, 1);
    if (w) shadow[a] = d;
    else if (id == 0) exp0.push_back(shadow[a]);
    else exp1.push_back(shadow[a]);
    if (id == 0) req0 = 0; else req1 = 0;
  endtask

  task automatic drain();
    repeat (6) tick();
    check("drain0", exp0.size(), 0);
    check("drain1", exp1.size(), 0);
  endtask

  initial begin
    int t_prev, n, seq;
    for (int i = 0; i < 256; i++) begin mem[i] = 8'h00; shadow[i] = 8'h00; end
    repeat (3) tick();
    check("reset_outs", {gnt0, gnt1, rvalid0, rvalid1, read_en, write_en, address_loc, data_in, rdata}, 0);
    rst_n = 1;

    // write then read on requester 0
    wr_cnt = 0;
    do_cmd(0, 1, 8'h05, 8'hA5);
    do_cmd(0, 0, 8'h05, 8'h00);
    drain();
    check("t1_write_cycles", wr_cnt, 1);

    // preload, reset, then a tie of reads
    do_cmd(0, 1, 8'h01, 8'h11);
    do_cmd(1, 1, 8'h02, 8'h22);
    drain();
    rst_n = 0; tick(); rst_n = 1;
    gnt_log.delete();
    fork
      do_cmd(0, 0, 8'h01, 8'h00);
      do_cmd(1, 0, 8'h02, 8'h00);
    join
    drain();
    check("t2_ngnt", gnt_log.size(), 2);
    if (gnt_log.size() == 2) begin
      check("t2_first", gnt_log[0], 0);
      check("t2_second", gnt_log[1], 1);
    end

    // both hold requests for six grants
    gnt_log.delete();
    we0 = 0; we1 = 0; addr0 = 8'h01; addr1 = 8'h02;
    req0 = 1; req1 = 1; n = 0;
    for (int i = 0; i < 60 && n < 6; i++) begin
      tick();
      if (gnt0) begin exp0.push_back(shadow[8'h01]); n++; end
      if (gnt1) begin exp1.push_back(shadow[8'h02]); n++; end
    end
    req0 = 0; req1 = 0;
    drain();
    check("t3_ngnt", gnt_log.size(), 6);
    for (int i = 0; i < gnt_log.size(); i++) begin
`ifdef ARB_FIXED_PRIO_EN
      seq = 0;
`else
      seq = i % 2;
`endif
      check("t3_order", gnt_log[i], seq);
    end

    // back-to-back writes on requester 1
    rd_cnt = 0; t_prev = -1;
    we1 = 1; addr1 = 8'h10; wdata1 = 8'h50; req1 = 1; n = 0;
    for (int i = 0; i < 40 && n < 4; i++) begin
      tick();
      if (gnt1) begin
        shadow[addr1] = wdata1;
        if (t_prev >= 0) check("t4_spacing", cyc - t_prev, 2);
        t_prev = cyc; n++;
        addr1 = addr1 + 8'h01; wdata1 = wdata1 + 8'h07;
        if (n == 4) req1 = 0;
      end
    end
    check("t4_ngnt", n, 4);
    repeat (2) tick();
    check("t4_no_read", rd_cnt, 0);
    for (int k = 0; k < 4; k++) do_cmd(1, 0, 8'h10 + 8'(k), 8'h00);
    drain();

    // reset during the capture cycle of a read
    do_cmd(0, 0, 8'h05, 8'h00);
    tick();
    rst_n = 0;
    exp0.delete();
    tick();
    check("t5_outs", {gnt0, gnt1, rvalid0, rvalid1, read_en, write_en, address_loc, data_in, rdata}, 0);
    rst_n = 1;
    gnt_log.delete();
    fork
      do_cmd(0, 0, 8'h01, 8'h00);
      do_cmd(1, 0, 8'h02, 8'h00);
    join
    drain();
    check("t5_ngnt", gnt_log.size(), 2);
    if (gnt_log.size() > 0) check("t5_tie_first", gnt_log[0], 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
